// File: rtl/serial_addsub_seq.sv
// Bit-serial add (optionally subtract) unit: one NAND-built full adder walks the operands LSB-first.
// Optional feature macro: SERIAL_SUB_EN adds the sub port for two's-complement A-B.
module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Handshake: start is taken only on an edge where ready=1 (IDLE); done is a
    // one-cycle pulse during which sum/cout are valid, and they hold until the next accept.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic             cy_q;
    logic             sub_op;
    logic             accept;

`ifdef SERIAL_SUB_EN
    assign sub_op = sub;
`else
    assign sub_op = 1'b0;
`endif

    assign accept = (state == IDLE) && start;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // Full adder: two NAND half adders; each half adder's first NAND is its
    // inverted carry, so the carry OR collapses to a single NAND of those.
    logic ha1_n, ha1_p, ha2_n, fa_s, fa_c;

    assign ha1_n = nand2(a_sh[0], b_sh[0]);
    assign ha1_p = nand2(nand2(a_sh[0], ha1_n), nand2(b_sh[0], ha1_n));
    assign ha2_n = nand2(ha1_p, cy_q);
    assign fa_s  = nand2(nand2(ha1_p, ha2_n), nand2(cy_q, ha2_n));
    assign fa_c  = nand2(ha1_n, ha2_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            cy_q <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= sub_op ? ~b : b;
            cnt  <= '0;
            cy_q <= sub_op;
        end else if (state == SHIFT) begin
            sum  <= {fa_s, sum[WIDTH-1:1]};
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            cy_q <= fa_c;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
                cout <= fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for serial_addsub_seq at WIDTH=4: vector table plus reset, ignore and back-to-back sequences.
module tb_serial_addsub_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    serial_addsub_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                                input logic [W-1:0] es, input logic ec);
        vec_t v;
        v.a = av; v.b = bv; v.sub = sv; v.exp_sum = es; v.exp_cout = ec;
        return v;
    endfunction

    // Compare the oldest scoreboard entry against the current result.
    task automatic score(input string name);
        logic [W:0] e;
        if (exp_q.size() == 0) begin
            check({name, " queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({name, " sum"}, {28'd0, sum}, {28'd0, e[W-1:0]});
            check({name, " cout"}, {31'd0, cout}, {31'd0, e[W]});
        end
    endtask

    // Driver: called on a negedge; waits for ready, accepts one op, checks timing and result.
    task automatic do_op(input vec_t v, input string name);
        int waited;
        int lat;
        int busy_n;
        waited = 0;
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, " ready_before"}, {31'd0, ready}, 1);
        a = v.a; b = v.b; sub = v.sub; start = 1'b1;
        exp_q.push_back({v.exp_cout, v.exp_sum});
        lat = -1;
        busy_n = 0;
        for (int j = 0; j < 4 * W; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                a = W'($urandom_range(0, (1 << W) - 1));
                b = W'($urandom_range(0, (1 << W) - 1));
                sub = ~v.sub;
            end
            if (done) begin
                lat = j;
                break;
            end
            if (busy) busy_n++;
        end
        check({name, " latency"}, lat, W);
        check({name, " busy_cycles"}, busy_n, W);
        score(name);
        repeat (2) @(negedge clk);
        check({name, " hold_sum"}, {28'd0, sum}, {28'd0, v.exp_sum});
        check({name, " hold_cout"}, {31'd0, cout}, {31'd0, v.exp_cout});
    endtask

    initial begin
        int n_done;
        int acc_j;
        logic [W-1:0] sums[2];

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        vecs.push_back(mk(4'd3,  4'd5,  1'b0, 4'd8,  1'b0));
        vecs.push_back(mk(4'd15, 4'd1,  1'b0, 4'd0,  1'b1));
        vecs.push_back(mk(4'd15, 4'd15, 1'b0, 4'd14, 1'b1));
        vecs.push_back(mk(4'd0,  4'd0,  1'b0, 4'd0,  1'b0));
        vecs.push_back(mk(4'd9,  4'd6,  1'b0, 4'd15, 1'b0));
        vecs.push_back(mk(4'd8,  4'd8,  1'b0, 4'd0,  1'b1));
        vecs.push_back(mk(4'd7,  4'd9,  1'b0, 4'd0,  1'b1));
        vecs.push_back(mk(4'd10, 4'd3,  1'b0, 4'd13, 1'b0));
`ifdef SERIAL_SUB_EN
        vecs.push_back(mk(4'd7,  4'd2,  1'b1, 4'd5,  1'b1));
        vecs.push_back(mk(4'd2,  4'd7,  1'b1, 4'd11, 1'b0));
        vecs.push_back(mk(4'd5,  4'd5,  1'b1, 4'd0,  1'b1));
        vecs.push_back(mk(4'd0,  4'd1,  1'b1, 4'd15, 1'b0));
        vecs.push_back(mk(4'd15, 4'd0,  1'b1, 4'd15, 1'b1));
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ready", {31'd0, ready}, 1);
        check("reset busy",  {31'd0, busy},  0);
        check("reset done",  {31'd0, done},  0);
        check("reset sum",   {28'd0, sum},   0);
        check("reset cout",  {31'd0, cout},  0);

        foreach (vecs[i]) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // reset held two cycles in the middle of 9+6
        a = 4'd9; b = 4'd6; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst ready", {31'd0, ready}, 1);
        check("midrst busy",  {31'd0, busy},  0);
        check("midrst done",  {31'd0, done},  0);
        check("midrst sum",   {28'd0, sum},   0);
        check("midrst cout",  {31'd0, cout},  0);
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst no_done", n_done, 0);

        // start kept high through SHIFT and DONE must not queue a second op
        a = 4'd3; b = 4'd5; sub = 1'b0; start = 1'b1;
        exp_q.push_back({1'b0, 4'd8});
        n_done = 0;
        for (int j = 0; j <= W; j++) begin
            @(negedge clk);
            a = 4'd1; b = 4'd1;
            check($sformatf("ignore ready_low%0d", j), {31'd0, ready}, 0);
            if (done) n_done++;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ignore one_done", n_done, 1);
        score("ignore");

        // start held high: two accepts WIDTH+2 edges apart
        a = 4'd1; b = 4'd2; sub = 1'b0; start = 1'b1;
        exp_q.push_back({1'b0, 4'd3});
        exp_q.push_back({1'b0, 4'd8});
        n_done = 0;
        acc_j = -1;
        sums[0] = '0; sums[1] = '0;
        for (int j = 0; j < 30 && n_done < 2; j++) begin
            @(negedge clk);
            if (j == 0) begin
                a = 4'd4; b = 4'd4;
            end
            if (done) begin
                score($sformatf("held op%0d", n_done));
                sums[n_done] = sum;
                n_done++;
            end
            if (ready && start && acc_j < 0) acc_j = j;
        end
        start = 1'b0;
        check("held done_count", n_done, 2);
        check("held accept_gap", acc_j + 1, W + 2);
        check("held first_sum", {28'd0, sums[0]}, 3);
        check("held second_sum", {28'd0, sums[1]}, 8);

        check("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
